// File: rtl/demux14_pkg.sv
// demux14_pkg: shared constants and types for the demux14_router slice.
//   NUM_CH        number of output channels
//   SEL_W         width of the channel select
//   DEF_W         default item width
//   DEF_CNT_W     default delivered-counter width
//   slot_state_e  per-channel holding-slot state
package demux14_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux14_slot.sv
// demux14_slot: one output channel of the demux -- a one-entry holding slot
// with valid/ready handshake on the read side and a delivered-item counter.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   wr_en      load wr_data into the slot this cycle (the caller guarantees
//              the slot is empty or draining in the same cycle)
//   wr_data    item to load
//   rd_ready   consumer takes the item this cycle
//   valid      slot holds an item
//   data       slot payload (keeps its last value after drain)
//   count      number of items delivered, wraps at 2^CNT_W
module demux14_slot
    import demux14_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [CNT_W-1:0] count
);

    slot_state_e      state_r;
    slot_state_e      state_nxt_s;
    logic [W-1:0]     data_r;
    logic [CNT_W-1:0] count_r;
    logic             drain_s;

    // A drain only happens when the slot actually holds an item.
    assign drain_s = (state_r == SLOT_FULL) && rd_ready;

    // Next-state logic: a simultaneous drain and reload keeps the slot full.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (wr_en) begin
                    state_nxt_s = SLOT_FULL;
                end else begin
                    state_nxt_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (drain_s && !wr_en) begin
                    state_nxt_s = SLOT_EMPTY;
                end else begin
                    state_nxt_s = SLOT_FULL;
                end
            end
            default: begin
                state_nxt_s = SLOT_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Payload register: loads only on write, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {W{1'b0}};
        end else if (wr_en) begin
            data_r <= wr_data;
        end else begin
            data_r <= data_r;
        end
    end

    // Delivered counter: one per completed handshake, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (drain_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign valid = (state_r == SLOT_FULL);
    assign data  = data_r;
    assign count = count_r;

endmodule

// File: rtl/demux14_router.sv
// demux14_router: registered 1-to-4 demultiplexer with valid/ready handshakes.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_valid    producer has an item on in_data/in_sel
//   in_ready    item accepted this cycle (depends only on the addressed channel)
//   in_data     item payload
//   in_sel      destination channel 0..3
//   out_valid   bit k: channel k holds an item
//   out_ready   bit k: consumer k takes the item this cycle
//   out_data    channel k payload at [k*W +: W]
//   out_count   channel k delivered count at [k*CNT_W +: CNT_W]
module demux14_router
    import demux14_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*W-1:0]     out_data,
    output logic [NUM_CH*CNT_W-1:0] out_count
);

    logic              in_ready_s;
    logic              accept_s;
    logic [NUM_CH-1:0] wr_en_s;

    // The addressed slot can take an item if it is empty or draining now;
    // the other channels never stall the producer.
    assign in_ready_s = !out_valid[in_sel] || out_ready[in_sel];
    assign in_ready   = in_ready_s;
    assign accept_s   = in_valid && in_ready_s;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            assign wr_en_s[k] = accept_s && (in_sel == SEL_W'(k));

            demux14_slot #(
                .W     (W),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .wr_en    (wr_en_s[k]),
                .wr_data  (in_data),
                .rd_ready (out_ready[k]),
                .valid    (out_valid[k]),
                .data     (out_data[k*W +: W]),
                .count    (out_count[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_demux14_router.sv
// tb_demux14_router: directed self-checking bench for demux14_router.
// A per-channel queue holds the items the bench expects in each slot; items
// are pushed when the bench's own handshake model accepts them and popped
// when the model sees the consumer take them.
module tb_demux14_router;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [31:0] out_count;

    int n_assert;
    int n_fail;

    logic [7:0] exp_q [4][$];
    logic [7:0] cnt_m [4];

    demux14_router #(.W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            cnt_m[k] = 8'd0;
        end
    endtask

    // One clock cycle with the inputs currently driven; checks in_ready before
    // the edge and all outputs against the model on the following negedge.
    task automatic step();
        logic       rdy_m;
        logic       acc_m;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] v_m;
        #1;
        s     = in_sel;
        d     = in_data;
        rdy_m = (exp_q[s].size() == 0) || out_ready[s];
        acc_m = in_valid && rdy_m;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_m});
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (exp_q[k].size() != 0 && out_ready[k]) begin
                void'(exp_q[k].pop_front());
                cnt_m[k] = cnt_m[k] + 8'd1;
            end
        end
        if (acc_m) exp_q[s].push_back(d);
        @(negedge clk);
        for (int k = 0; k < 4; k++) v_m[k] = (exp_q[k].size() != 0);
        chk("out_valid", {28'd0, out_valid}, {28'd0, v_m});
        chk("out_count", out_count, {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]});
        for (int k = 0; k < 4; k++) begin
            if (v_m[k]) chk($sformatf("out_data%0d", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, exp_q[k][0]});
        end
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
        model_clear();

        // Power-on reset state.
        repeat (2) @(negedge clk);
        chk("rst_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_count", out_count, 32'd0);
        rst = 1'b0;

        // Idle with all consumers ready: nothing moves, counts stay zero.
        out_ready = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            in_sel = 2'(i);
            idle();
        end
        chk("idle_count", out_count, 32'd0);
        chk("idle_valid", {28'd0, out_valid}, 32'd0);

        // Basic steer: one item per channel on consecutive cycles.
        send(2'd0, 8'hA0);
        chk("steer0_only", {28'd0, out_valid}, 32'h1);
        send(2'd1, 8'hA1);
        send(2'd2, 8'hA2);
        send(2'd3, 8'hA3);
        idle();
        chk("steer_counts", out_count, 32'h01010101);

        // Back-pressure on channel 2.
        out_ready = 4'b1011;
        send(2'd2, 8'h55);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 8'h66;
        #1;
        chk("bp_blocked", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_hold", {24'd0, out_data[23:16]}, 32'h55);
        send(2'd1, 8'h77);
        out_ready[2] = 1'b1;
        send(2'd2, 8'h66);
        chk("bp_refill", {24'd0, out_data[23:16]}, 32'h66);
        idle();
        chk("bp_count2", {24'd0, out_count[23:16]}, 32'd3);

        // Streaming: ten back-to-back items to channel 3.
        out_ready = 4'b1111;
        for (int i = 0; i < 10; i++) send(2'd3, 8'h30 + 8'(i));
        idle();
        chk("stream_count3", {24'd0, out_count[31:24]}, 32'd11);

        // Reset with all four slots full.
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) send(2'(i), 8'hC0 + 8'(i));
        chk("full_before_rst", {28'd0, out_valid}, 32'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {28'd0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_count", out_count, 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i);
            #1;
            chk($sformatf("arst_ready%0d", i), {31'd0, in_ready}, 32'd1);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Counter wrap on channel 0: 256 deliveries from zero.
        out_ready = 4'b0001;
        for (int i = 0; i < 256; i++) send(2'd0, 8'(i));
        idle();
        chk("wrap_count0", {24'd0, out_count[7:0]}, 32'd0);
        chk("wrap_others", {8'd0, out_count[31:8]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
